sub_bytes_engine: RTL and testbench

Sequential, parametrised AES byte-substitution layer. It accepts one 128-bit state over a valid/ready handshake and substitutes `LANES` bytes per clock. It supports both forward (encrypt) and inverse (decrypt) S-box mode, and presents the result on a registered valid/ready output. It sits between the AddRoundKey and ShiftRows stages of the round datapath. It replaces the purely combinational 16-byte substitution layer, trading area for latency.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/sbox_byte.sv | 12 +
 rtl/sub_bytes_engine.sv | 106 ++++++++++
 tb/tb_sub_bytes_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: forward/inverse S-box tables and the substitution engine state type.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sbe_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_byte.sv
// Single-byte AES substitution; the inverse select chooses between the two package tables.
module sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inverse,
    output logic [7:0] dout
);

    assign dout = inverse ? INV_SBOX[din] : SBOX[din];

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes: one 128-bit block in, LANES bytes substituted per clock,
// most significant chunk first, result held on a registered valid/ready output.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int CHUNKS = AES_BLOCK_BYTES / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CBITS  = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $fatal(1, "sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sbe_state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [CHUNKS-1:0][CBITS-1:0] work;
    logic mode;
    logic load, step;
    logic [CBITS-1:0] chunk_in, chunk_out;

    // Chunk 0 is the most significant slice of the block, i.e. the highest packed index.
    assign idx      = LAST - cnt;
    assign chunk_in = work[idx];

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            sbox_byte u_sbox (
                .din     (chunk_in[8*(LANES-1-l) +: 8]),
                .inverse (mode),
                .dout    (chunk_out[8*(LANES-1-l) +: 8])
            );
        end
    endgenerate

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // out_valid is its own flop so the output port never sees decode logic.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt  <= '0;
            work <= '0;
            mode <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            work <= in_data;
            mode <= in_inverse;
        end else if (step) begin
            work[idx] <= chunk_out;
            cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign out_data = work;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench: LANES=4 engine for function, handshake, backpressure and reset,
// plus a side-by-side sweep of LANES=1,2,8,16 fed with the same blocks.
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         sw_valid;
    logic [127:0] sw_data;
    logic         sw_inv;
    logic         sw_oready;
    logic         sw_ir   [4];
    logic         sw_ov   [4];
    logic [127:0] sw_od   [4];
    logic         sw_busy [4];

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] V_C2   = {16{8'hc2}};
    localparam logic [127:0] V_25   = {16{8'h25}};
    localparam logic [127:0] V_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V_SB   = 128'h638293c31bfc33f5c4eeacea4bc12816;

    always #5 clk = ~clk;

    sub_bytes_engine #(.LANES(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_inverse (in_inverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sweep
            sub_bytes_engine #(.LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16)) u_sw (
                .clk        (clk),
                .n_rst      (n_rst),
                .in_valid   (sw_valid),
                .in_ready   (sw_ir[g]),
                .in_data    (sw_data),
                .in_inverse (sw_inv),
                .out_valid  (sw_ov[g]),
                .out_ready  (sw_oready),
                .out_data   (sw_od[g]),
                .busy       (sw_busy[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on the LANES=4 engine and count edges until out_valid.
    task automatic run_block(input logic [127:0] d, input logic inv,
                             output logic [127:0] res, output int lat);
        in_valid   = 1'b1;
        in_data    = d;
        in_inverse = inv;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        res = out_data;
    endtask

    task automatic sweep(input string tag, input logic [127:0] d, input logic inv,
                         input logic [127:0] exp);
        int lat [4];
        logic [127:0] res [4];
        int exp_lat [4];
        exp_lat = '{16, 8, 2, 1};
        for (int k = 0; k < 4; k++) begin
            lat[k] = 0;
            res[k] = '0;
        end
        sw_valid = 1'b1;
        sw_data  = d;
        sw_inv   = inv;
        step();
        sw_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int k = 0; k < 4; k++)
                if (sw_ov[k] && lat[k] == 0) begin
                    lat[k] = c;
                    res[k] = sw_od[k];
                end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_data_k%0d", tag, k), res[k], exp);
            chk($sformatf("%s_lat_k%0d", tag, k), 128'(lat[k]), 128'(exp_lat[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        int lat;
        logic stable;

        n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_inverse = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_data = '0; sw_inv = 1'b0; sw_oready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        n_rst = 1'b1;
        step();

        // Basic forward and inverse blocks, one handshake each.
        run_block(V_C2, 1'b0, res, lat);
        chk("fwd_c2_data", res, V_25);
        chk("fwd_c2_lat", 128'(lat), 128'(4));
        step();
        chk("fwd_c2_idle", 128'(in_ready), 128'(1));

        run_block(V_PT, 1'b0, res, lat);
        chk("fwd_pt_data", res, V_SB);
        step();
        run_block(V_SB, 1'b1, res, lat);
        chk("inv_sb_data", res, V_PT);
        chk("inv_sb_lat", 128'(lat), 128'(4));
        step();
        run_block(V_25, 1'b1, res, lat);
        chk("inv_25_data", res, V_C2);
        step();

        // Backpressure, with upstream changing its inputs while RUN is in progress.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = V_PT;
        in_inverse = 1'b0;
        step();
        in_valid   = 1'b0;
        in_data    = {128{1'b1}};
        in_inverse = 1'b1;
        chk("run_busy", 128'(busy), 128'(1));
        chk("run_in_ready", 128'(in_ready), 128'(0));
        step(); step(); step();
        chk("run_no_valid_early", 128'(out_valid), 128'(0));
        step();
        chk("bp_valid", 128'(out_valid), 128'(1));
        chk("bp_data", out_data, V_SB);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!out_valid || out_data !== V_SB || in_ready || !busy) stable = 1'b0;
        end
        chk("bp_hold_5", 128'(stable), 128'(1));
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_ready", 128'(in_ready), 128'(1));

        // Reset during RUN discards the block.
        in_valid   = 1'b1;
        in_data    = V_C2;
        in_inverse = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_data", out_data, '0);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) stable = 1'b0;
        end
        chk("mid_rst_no_valid", 128'(stable), 128'(1));
        run_block(V_SB, 1'b1, res, lat);
        chk("post_rst_data", res, V_PT);
        chk("post_rst_lat", 128'(lat), 128'(4));
        step();

        sweep("sw_fwd", V_PT, 1'b0, V_SB);
        sweep("sw_inv", V_25, 1'b1, V_C2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
